// File: rtl/fios_pkg.sv
// Shared constants, state encoding and limb slicing helper for the FIOS result collector.
package fios_pkg;

   localparam int LIMB_WIDTH = 17;
   localparam int P_WIDTH    = 2 * LIMB_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } collect_state_t;

   // Base bit position of limb k inside a packed multi-limb vector.
   function automatic int limb_idx(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/limb_carry_add.sv
// Adds a DSP partial-sum word to the running carry and splits the sum into a
// result limb and the carry for the next limb position.
module limb_carry_add #(
   parameter int LIMB_WIDTH = fios_pkg::LIMB_WIDTH,
   parameter int P_WIDTH    = fios_pkg::P_WIDTH
) (
   input  logic [P_WIDTH-1:0]    p,
   input  logic [LIMB_WIDTH:0]   carry_in,
   output logic [LIMB_WIDTH-1:0] limb,
   output logic [LIMB_WIDTH:0]   carry_out
);
   import fios_pkg::*;

   // One extra bit so the carry-out of the word plus carry is never lost.
   logic [P_WIDTH:0] sum;

   assign sum       = {1'b0, p} + (P_WIDTH + 1)'(carry_in);
   assign limb      = sum[LIMB_WIDTH-1:0];
   assign carry_out = sum[LIMB_WIDTH +: LIMB_WIDTH + 1];

endmodule

// File: rtl/fios_result_collector.sv
// Collects N_LIMBS carry-propagated limbs from the DSP partial-sum stream and
// hands the assembled result downstream. Optional macro: FIOS_COLLECT_OVF_EN.
module fios_result_collector #(
   parameter int LIMB_WIDTH = fios_pkg::LIMB_WIDTH,
   parameter int N_LIMBS    = 16,
   parameter int P_WIDTH    = fios_pkg::P_WIDTH
) (
   input  logic                          clock_i,
   input  logic                          rst_n_i,
   input  logic                          start_i,
   input  logic [P_WIDTH-1:0]            P_i,
   input  logic                          P_valid_i,
   input  logic                          result_ready_i,
   output logic                          busy_o,
   output logic [N_LIMBS*LIMB_WIDTH-1:0] result_o,
   output logic                          result_valid_o,
   output logic [LIMB_WIDTH:0]           carry_o
`ifdef FIOS_COLLECT_OVF_EN
   ,
   output logic                          overflow_o
`endif
);
   import fios_pkg::*;

   localparam int CNT_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LIMBS - 1);

   collect_state_t            state_reg;
   collect_state_t            state_next;
   logic [CNT_W-1:0]          cnt_reg;
   logic [LIMB_WIDTH:0]       carry_reg;
   logic [LIMB_WIDTH:0]       carry_next;
   logic [LIMB_WIDTH-1:0]     limb_next;
   logic                      accept;
   logic                      last_accept;
   logic                      restart;

   assign accept      = (state_reg == COLLECT) && P_valid_i;
   assign last_accept = accept && (cnt_reg == LAST_CNT);
   // A new collection may begin from IDLE or on the very cycle the result is taken.
   assign restart     = start_i && ((state_reg == IDLE) ||
                                    ((state_reg == DONE) && result_ready_i));

   limb_carry_add #(
      .LIMB_WIDTH (LIMB_WIDTH),
      .P_WIDTH    (P_WIDTH)
   ) u_limb_carry_add (
      .p         (P_i),
      .carry_in  (carry_reg),
      .limb      (limb_next),
      .carry_out (carry_next)
   );

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (last_accept) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (result_ready_i) begin
               state_next = start_i ? COLLECT : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o         = 1'b0;
      result_valid_o = 1'b0;
      case (state_reg)
         COLLECT: busy_o = 1'b1;
         DONE: begin
            busy_o         = 1'b1;
            result_valid_o = 1'b1;
         end
         default: ;
      endcase
   end

   // The carry left after the last limb stays in carry_reg through DONE.
   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_reg   <= '0;
         carry_reg <= '0;
      end else if (restart) begin
         cnt_reg   <= '0;
         carry_reg <= '0;
      end else if (accept) begin
         cnt_reg   <= cnt_reg + 1'b1;
         carry_reg <= carry_next;
      end
   end

   assign carry_o = carry_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_LIMBS; gi++) begin : g_limb
         logic [LIMB_WIDTH-1:0] limb_reg;

         always_ff @(posedge clock_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               limb_reg <= '0;
            end else if (accept && (cnt_reg == CNT_W'(gi))) begin
               limb_reg <= limb_next;
            end
         end

         assign result_o[limb_idx(gi, LIMB_WIDTH) +: LIMB_WIDTH] = limb_reg;
      end
   endgenerate

`ifdef FIOS_COLLECT_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_reg <= 1'b0;
      end else if (restart) begin
         ovf_reg <= 1'b0;
      end else if (last_accept) begin
         ovf_reg <= |carry_next;
      end
   end

   assign overflow_o = ovf_reg;
`endif

endmodule

// File: tb/tb_fios_result_collector.sv
// Randomized scoreboard bench for fios_result_collector with a 4-limb build;
// expected results come from a weighted-sum model of the accepted words.
module tb_fios_result_collector;

   localparam int LW = 17;
   localparam int NL = 4;
   localparam int PW = 34;
   localparam int RW = NL * LW;

   typedef logic [PW-1:0] words_t [NL];

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start   = 1'b0;
   logic          p_valid = 1'b0;
   logic          ready   = 1'b0;
   logic [PW-1:0] p       = '0;
   logic          busy;
   logic          res_valid;
   logic [RW-1:0] result;
   logic [LW:0]   carry;
`ifdef FIOS_COLLECT_OVF_EN
   logic          overflow;
   logic          exp_ovf_q [$];
`endif

   int            checks = 0;
   int            errors = 0;
   int            txn_no = 0;
   logic [RW-1:0] exp_q [$];

   always #5 clk = ~clk;

   fios_result_collector #(
      .LIMB_WIDTH (LW),
      .N_LIMBS    (NL),
      .P_WIDTH    (PW)
   ) dut (
      .clock_i        (clk),
      .rst_n_i        (rst_n),
      .start_i        (start),
      .P_i            (p),
      .P_valid_i      (p_valid),
      .result_ready_i (ready),
      .busy_o         (busy),
      .result_o       (result),
      .result_valid_o (res_valid),
      .carry_o        (carry)
`ifdef FIOS_COLLECT_OVF_EN
      ,
      .overflow_o     (overflow)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Value of the words placed at their limb weights, words 0..upto.
   function automatic logic [127:0] weighted_sum(input words_t w, input int upto);
      logic [127:0] s;
      s = '0;
      for (int k = 0; k <= upto; k++) begin
         s = s + (128'(w[k]) << (LW * k));
      end
      return s;
   endfunction

   function automatic logic [PW-1:0] rand_word();
      logic [PW-1:0] w;
      w[31:0]    = $urandom;
      w[PW-1:32] = 2'($urandom_range(3, 0));
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every handshake and checks hold stability.
   logic          hold_valid = 1'b0;
   logic [RW-1:0] hold_result = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) begin
            check("hold_valid", res_valid, 1);
            check("hold_result", result, hold_result);
         end
         if (res_valid && ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result_unexpected: got 0x%0h, expected no result", result);
            end else begin
               logic [RW-1:0] e;
               e = exp_q.pop_front();
               check("result", result, e);
               $display("txn %0d: result=0x%0h expected=0x%0h", txn_no, result, e);
               txn_no++;
            end
`ifdef FIOS_COLLECT_OVF_EN
            if (exp_ovf_q.size() != 0) begin
               logic eo;
               eo = exp_ovf_q.pop_front();
               check("overflow", overflow, eo);
            end
`endif
            hold_valid = 1'b0;
         end else if (res_valid) begin
            hold_valid  = 1'b1;
            hold_result = result;
         end else begin
            hold_valid = 1'b0;
         end
      end
   end

   // One full collection: optional start, words with gaps, backpressure, handshake.
   task automatic run_txn(input words_t w, input int gap, input int hold,
                          input bit do_start, input bit chain, input bit mid_start);
      logic [127:0] total;
      logic [127:0] expc;
      total = weighted_sum(w, NL - 1);
      exp_q.push_back(total[RW-1:0]);
`ifdef FIOS_COLLECT_OVF_EN
      exp_ovf_q.push_back(total[127:RW] != 0);
`endif
      if (do_start) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      check("start_busy", busy, 1);
      check("start_carry", carry, 0);
      for (int j = 0; j < NL; j++) begin
         check("pre_valid", res_valid, 0);
         p_valid = 1'b1;
         p       = w[j];
         start   = mid_start && (j == 2);
         step();
         p_valid = 1'b0;
         start   = 1'b0;
         p       = rand_word();
         expc    = weighted_sum(w, j) >> (LW * (j + 1));
         check("carry", carry, expc);
         check("busy", busy, 1);
         if (j < NL - 1) begin
            for (int g = 0; g < gap; g++) begin
               step();
               check("gap_busy", busy, 1);
               check("gap_valid", res_valid, 0);
            end
         end
      end
      check("valid_latency", res_valid, 1);
      for (int h = 0; h < hold; h++) begin
         p_valid = 1'b1;
         p       = 34'h5;
         start   = (h % 2) == 1;
         step();
      end
      p_valid = 1'b0;
      start   = 1'b0;
      check("done_carry", carry, total >> RW);
      check("done_valid", res_valid, 1);
      ready = 1'b1;
      start = chain;
      step();
      ready = 1'b0;
      start = 1'b0;
      check("post_valid", res_valid, 0);
      check("post_busy", busy, chain ? 1 : 0);
      if (chain) begin
         check("chain_carry", carry, 0);
      end
   endtask

   initial begin
      words_t w;
      bit     prev_chain;
      bit     chain;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Words offered in IDLE must be ignored
      p_valid = 1'b1;
      p       = 34'h3_FFFF_FFFF;
      step();
      step();
      p_valid = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_carry", carry, 0);

      // Basic carry
      w = '{34'h3FFFF, 34'h0, 34'h0, 34'h0};
      run_txn(w, 0, 0, 1'b1, 1'b0, 1'b0);
      check("basic_result", result, 68'h3FFFF);

      // Max operands
      w = '{34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF};
      run_txn(w, 0, 0, 1'b1, 1'b0, 1'b0);

      // Gaps between words
      w = '{34'h3FFFF, 34'h0, 34'h0, 34'h0};
      run_txn(w, 3, 0, 1'b1, 1'b0, 1'b0);

      // Backpressure in DONE
      w = '{rand_word(), rand_word(), rand_word(), rand_word()};
      run_txn(w, 0, 5, 1'b1, 1'b0, 1'b0);

      // Start pulse during COLLECT is ignored
      w = '{rand_word(), rand_word(), rand_word(), rand_word()};
      run_txn(w, 1, 0, 1'b1, 1'b0, 1'b1);

      // Reset mid-run after two words
      start = 1'b1;
      step();
      start   = 1'b0;
      p_valid = 1'b1;
      p       = rand_word();
      step();
      p = rand_word();
      step();
      p_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", res_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_carry", carry, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      w = '{rand_word(), rand_word(), rand_word(), rand_word()};
      run_txn(w, 0, 0, 1'b1, 1'b0, 1'b0);

      // Start together with the handshake chains straight into COLLECT
      w = '{rand_word(), rand_word(), rand_word(), rand_word()};
      run_txn(w, 0, 2, 1'b1, 1'b1, 1'b0);
      w = '{rand_word(), 34'h0, rand_word(), 34'h1};
      run_txn(w, 0, 0, 1'b0, 1'b0, 1'b0);

      // Randomized transactions
      prev_chain = 1'b0;
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < NL; k++) begin
            w[k] = ($urandom_range(3, 0) == 0) ? PW'($urandom_range(255, 0)) : rand_word();
         end
         chain = (t < 19) && ($urandom_range(1, 0) == 1);
         run_txn(w, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                 !prev_chain, chain, $urandom_range(3, 0) == 0);
         prev_chain = chain;
      end

      repeat (2) step();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
